// File: rtl/addsub_chain_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract chain.
// Holds the chain state encoding and the operation mode encoding. The top
// level and the testbench both import these definitions.
package addsub_chain_seq_pkg;

  // START: the next accepted pair is the least-significant word.
  // CHAIN: a multi-word operation is in progress.
  typedef enum logic {
    ST_START = 1'b0,
    ST_CHAIN = 1'b1
  } chain_state_t;

  // Encoding of add_sub and of the latched operation mode.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : addsub_chain_seq_pkg

// File: rtl/addsub_chain_seq_if.sv
// Operand/result handshake bundle for addsub_chain_seq.
//   Operand side: in_valid/in_ready handshake, with in_last, add_sub,
//     carry_in, A and B.
//   Result side: out_valid/out_ready handshake, with out_sum, out_last,
//     out_carry_out and out_overflow.
// master: the producer of operands and consumer of results (operand fetch
//   and writeback side). slave: the chain block itself.
interface addsub_chain_seq_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic                  add_sub;
  logic                  carry_in;
  logic [WORD_WIDTH-1:0] A;
  logic [WORD_WIDTH-1:0] B;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_sum;
  logic                  out_last;
  logic                  out_carry_out;
  logic                  out_overflow;

  modport master (
    output in_valid, in_last, add_sub, carry_in, A, B, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_carry_out, out_overflow
  );

  modport slave (
    input  in_valid, in_last, add_sub, carry_in, A, B, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_carry_out, out_overflow
  );
endinterface : addsub_chain_seq_if

// File: rtl/addsub_chain_seq_addsub_bin.sv
// addsub_bin: combinational ripple-carry adder/subtractor for one slice.
//   a, b       operands
//   cin        carry in (a borrow-in is expressed by the caller as ~borrow)
//   add_sub    0 = a + b + cin, 1 = a + ~b + cin
//   sum        result slice
//   carry_out  carry out of the top bit
//   overflow   signed overflow (carry into top bit xor carry out of it)
//   carries    carry out of every bit position
module addsub_bin #(
  parameter int WORD_WIDTH = 16
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  add_sub,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [WORD_WIDTH-1:0] carries
);
  logic [WORD_WIDTH-1:0] b_eff_s;
  logic [WORD_WIDTH:0]   chain_s;

  assign b_eff_s    = add_sub ? ~b : b;
  assign chain_s[0] = cin;

  for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b_eff_s[i] ^ chain_s[i];
    assign chain_s[i+1] = (a[i] & b_eff_s[i]) | (a[i] & chain_s[i]) | (b_eff_s[i] & chain_s[i]);
  end

  assign carries   = chain_s[WORD_WIDTH:1];
  assign carry_out = chain_s[WORD_WIDTH];
  assign overflow  = chain_s[WORD_WIDTH] ^ chain_s[WORD_WIDTH-1];
endmodule : addsub_bin

// File: rtl/addsub_chain_seq.sv
// addsub_chain_seq: sequential multi-precision adder/subtractor.
// Operand word pairs arrive least-significant word first; each produces one
// registered result slice on the following cycle.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   io       operand/result handshake bundle (slave side)
// Subtraction is done here by inverting B and the borrow, so the slice
// adder always runs in add mode and the inter-word carry has one meaning:
// for subtraction a carry of 1 means "no borrow".
module addsub_chain_seq
  import addsub_chain_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input logic                clock,
  input logic                reset_n,
  addsub_chain_seq_if.slave  io
);
  chain_state_t          state_r;
  chain_state_t          state_nx_s;
  logic                  mode_r;
  logic                  carry_r;
  logic                  out_valid_r;
  logic [WORD_WIDTH-1:0] out_sum_r;
  logic                  out_last_r;
  logic                  out_carry_r;
  logic                  out_overflow_r;

  logic                  accept_s;
  logic                  first_s;
  logic                  mode_s;
  logic                  cin_s;
  logic [WORD_WIDTH-1:0] b_eff_s;
  logic [WORD_WIDTH-1:0] sum_s;
  logic                  carry_s;
  logic                  overflow_s;

  assign io.in_ready      = !out_valid_r || io.out_ready;
  assign accept_s         = io.in_valid && io.in_ready;
  assign first_s          = (state_r == ST_START);

  assign io.out_valid     = out_valid_r;
  assign io.out_sum       = out_sum_r;
  assign io.out_last      = out_last_r;
  assign io.out_carry_out = out_carry_r;
  assign io.out_overflow  = out_overflow_r;

  // Operand conditioning: mode and carry come from the pins on the LSW and
  // from the latched registers for every later word.
  always_comb begin
    mode_s  = mode_r;
    cin_s   = carry_r;
    b_eff_s = io.B;
    if (first_s) begin
      mode_s = io.add_sub;
      cin_s  = (io.add_sub == MODE_SUB) ? ~io.carry_in : io.carry_in;
    end else begin
      mode_s = mode_r;
      cin_s  = carry_r;
    end
    if (mode_s == MODE_SUB) begin
      b_eff_s = ~io.B;
    end else begin
      b_eff_s = io.B;
    end
  end

  addsub_bin #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_addsub_bin (
    .a         (io.A),
    .b         (b_eff_s),
    .cin       (cin_s),
    .add_sub   (MODE_ADD),
    .sum       (sum_s),
    .carry_out (carry_s),
    .overflow  (overflow_s),
    .carries   ()
  );

  // Chain state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_START;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next chain state: the MSW always returns to START, any other word
  // leaves the operation in CHAIN.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_START: begin
        if (accept_s && !io.in_last) begin
          state_nx_s = ST_CHAIN;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_CHAIN: begin
        if (accept_s && io.in_last) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_CHAIN;
        end
      end
      default: state_nx_s = ST_START;
    endcase
  end

  // Latched mode, chain carry and the registered result slice.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_r         <= MODE_ADD;
      carry_r        <= 1'b0;
      out_valid_r    <= 1'b0;
      out_sum_r      <= '0;
      out_last_r     <= 1'b0;
      out_carry_r    <= 1'b0;
      out_overflow_r <= 1'b0;
    end else if (accept_s) begin
      // mode_s equals mode_r mid-chain, so this only changes on the LSW.
      mode_r         <= mode_s;
      carry_r        <= io.in_last ? 1'b0 : carry_s;
      out_valid_r    <= 1'b1;
      out_sum_r      <= sum_s;
      out_last_r     <= io.in_last;
      out_carry_r    <= carry_s;
      out_overflow_r <= overflow_s;
    end else if (io.out_ready) begin
      out_valid_r    <= 1'b0;
    end else begin
      out_valid_r    <= out_valid_r;
    end
  end
endmodule : addsub_chain_seq

// File: tb/tb_addsub_chain_seq.sv
// Self-checking bench for addsub_chain_seq with 16-bit slices. Results are
// collected by a negedge monitor into a queue and compared against fixed
// expected values or a whole-operand arithmetic reference model.
module tb_addsub_chain_seq;
  import addsub_chain_seq_pkg::*;

  localparam int W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  bit   rand_bp = 1'b0;

  // {sum[15:0], carry, overflow, last}
  logic [18:0] obs_q[$];
  logic [18:0] exp_q[$];

  addsub_chain_seq_if #(.WORD_WIDTH(W)) io ();

  addsub_chain_seq #(.WORD_WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io.slave)
  );

  always #5 clock = ~clock;

  // Record every slice that will transfer on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && io.out_valid === 1'b1 && io.out_ready === 1'b1)
      obs_q.push_back({io.out_sum, io.out_carry_out, io.out_overflow, io.out_last});
  end

  // Random downstream backpressure, changed just after each rising edge.
  always @(posedge clock) begin
    if (rand_bp) begin
      #2;
      io.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference: slice i of an n-word operation computed from whole operands.
  function automatic logic [18:0] ref_slice(input int n, input int i,
                                            input longint unsigned af, input longint unsigned bf,
                                            input logic sub, input logic cin);
    longint unsigned lo_mask, a_lo, b_lo, t;
    longint sa, sb, res, lim;
    int nb;
    logic c, ov;
    lo_mask = (64'd1 << (16 * (i + 1))) - 64'd1;
    a_lo = af & lo_mask;
    b_lo = bf & lo_mask;
    if (!sub) begin
      t = a_lo + b_lo + 64'(cin);
      c = t[16 * (i + 1)];
    end else begin
      t = a_lo - b_lo - 64'(cin);
      c = (a_lo >= b_lo + 64'(cin));
    end
    nb = 16 * n;
    sa = longint'(af << (64 - nb));
    sa = sa >>> (64 - nb);
    sb = longint'(bf << (64 - nb));
    sb = sb >>> (64 - nb);
    res = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    lim = longint'(64'd1 << (nb - 1));
    ov = (res >= lim) || (res < -lim);
    return {t[16 * i +: 16], c, ov, (i == n - 1)};
  endfunction

  task automatic drive_word(input logic [15:0] a, input logic [15:0] b,
                            input logic last, input logic sub, input logic cin);
    int cyc;
    io.A = a;
    io.B = b;
    io.in_last = last;
    io.add_sub = sub;
    io.carry_in = cin;
    io.in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (io.in_ready !== 1'b1 && cyc < 500);
    if (io.in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", io.in_ready, cyc);
    end
    @(posedge clock);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int cyc;
    cyc = 0;
    while (obs_q.size() < n && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    if (obs_q.size() < n) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d slices, required %0d", obs_q.size(), n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({io.out_valid, io.out_sum, io.out_last, io.out_carry_out, io.out_overflow} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b sum=%h last=%b co=%b ov=%b, required all 0",
               io.out_valid, io.out_sum, io.out_last, io.out_carry_out, io.out_overflow);
    end
    checks++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b required 1", io.in_ready);
    end
  endtask

  task automatic test_single_add;
    logic [18:0] e;
    obs_q.delete();
    drive_word(16'h7FFF, 16'h0001, 1'b1, MODE_ADD, 1'b0);
    drain(1);
    e = (obs_q.size() > 0) ? obs_q[0] : 19'hx;
    checks++;
    if (e !== {16'h8000, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL single_add: got %h required %h", e, {16'h8000, 1'b0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_two_word_add;
    logic [18:0] e0, e1;
    obs_q.delete();
    drive_word(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 1'b0);
    drive_word(16'h0001, 16'h0000, 1'b1, MODE_ADD, 1'b0);
    drain(2);
    e0 = (obs_q.size() > 0) ? obs_q[0] : 19'hx;
    e1 = (obs_q.size() > 1) ? obs_q[1] : 19'hx;
    checks++;
    if ((e0 & 19'h7FFFD) !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add2_lsw: got %h required sum=0000 co=1 last=0", e0);
    end
    checks++;
    if (e1 !== {16'h0002, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL add2_msw: got %h required %h", e1, {16'h0002, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_two_word_sub;
    logic [18:0] e0, e1;
    obs_q.delete();
    drive_word(16'h0000, 16'h0001, 1'b0, MODE_SUB, 1'b0);
    drive_word(16'h0001, 16'h0000, 1'b1, MODE_SUB, 1'b0);
    drain(2);
    e0 = (obs_q.size() > 0) ? obs_q[0] : 19'hx;
    e1 = (obs_q.size() > 1) ? obs_q[1] : 19'hx;
    checks++;
    if ((e0 & 19'h7FFFD) !== {16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL sub2_lsw: got %h required sum=FFFF co=0 last=0", e0);
    end
    checks++;
    if (e1 !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL sub2_msw: got %h required %h", e1, {16'h0000, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_backpressure;
    obs_q.delete();
    io.out_ready = 1'b0;
    io.A = 16'hFFFF;
    io.B = 16'h0001;
    io.in_last = 1'b0;
    io.add_sub = MODE_ADD;
    io.carry_in = 1'b0;
    io.in_valid = 1'b1;
    @(posedge clock);
    #1;
    io.A = 16'h0001;
    io.B = 16'h0000;
    io.in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({io.in_ready, io.out_valid, io.out_sum, io.out_carry_out, io.out_last} !==
          {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b sum=%h co=%b last=%b, required rdy=0 vld=1 sum=0000 co=1 last=0",
                 k, io.in_ready, io.out_valid, io.out_sum, io.out_carry_out, io.out_last);
      end
    end
    @(posedge clock);
    #1;
    io.out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (io.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b required 1", io.in_ready);
    end
    @(posedge clock);
    #1;
    io.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({io.out_valid, io.out_sum, io.out_carry_out, io.out_last} !== {1'b1, 16'h0002, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL bp_next_slice: got vld=%b sum=%h co=%b last=%b, required vld=1 sum=0002 co=0 last=1",
               io.out_valid, io.out_sum, io.out_carry_out, io.out_last);
    end
    drain(2);
    checks++;
    if (obs_q.size() !== 2) begin
      fails++;
      $display("FAIL bp_transfers: got %0d transfers required 2", obs_q.size());
    end
  endtask

  task automatic test_mode_change;
    logic [18:0] e1, e2;
    obs_q.delete();
    drive_word(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 1'b0);
    drive_word(16'h0001, 16'h0000, 1'b1, MODE_SUB, 1'b1);
    drive_word(16'h0005, 16'h0006, 1'b1, MODE_ADD, 1'b1);
    drain(3);
    e1 = (obs_q.size() > 1) ? obs_q[1] : 19'hx;
    e2 = (obs_q.size() > 2) ? obs_q[2] : 19'hx;
    checks++;
    if (e1 !== {16'h0002, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mode_ignored_mid_chain: got %h required %h", e1, {16'h0002, 1'b0, 1'b0, 1'b1});
    end
    checks++;
    if (e2 !== {16'h000C, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL cin_on_next_lsw: got %h required %h", e2, {16'h000C, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_chain;
    logic [18:0] e;
    obs_q.delete();
    drive_word(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (io.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_chain_valid: got %b required 0", io.out_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    obs_q.delete();
    drive_word(16'h0003, 16'h0004, 1'b1, MODE_ADD, 1'b0);
    drain(1);
    e = (obs_q.size() > 0) ? obs_q[0] : 19'hx;
    checks++;
    if (e !== {16'h0007, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_chain_next: got %h required %h", e, {16'h0007, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random;
    int n, gap;
    longint unsigned af, bf, mask;
    logic mode, cin, as_w, ci_w;
    obs_q.delete();
    exp_q.delete();
    rand_bp = 1'b1;
    for (int op = 0; op < 30; op++) begin
      n = $urandom_range(1, 3);
      mask = (64'd1 << (16 * n)) - 64'd1;
      af = {32'($urandom), 32'($urandom)} & mask;
      bf = {32'($urandom), 32'($urandom)} & mask;
      mode = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clock);
          #1;
        end
        as_w = (i == 0) ? mode : 1'($urandom_range(0, 1));
        ci_w = (i == 0) ? cin : 1'($urandom_range(0, 1));
        exp_q.push_back(ref_slice(n, i, af, bf, mode, cin));
        drive_word(af[16 * i +: 16], bf[16 * i +: 16], (i == n - 1), as_w, ci_w);
      end
    end
    rand_bp = 1'b0;
    @(posedge clock);
    #3;
    io.out_ready = 1'b1;
    drain(exp_q.size());
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rand_count: got %0d slices required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (exp_q[k][0] ? (obs_q[k] !== exp_q[k])
                      : ((obs_q[k] & 19'h7FFFD) !== (exp_q[k] & 19'h7FFFD))) begin
        fails++;
        $display("FAIL rand_slice[%0d]: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_last = 1'b0;
    io.add_sub = 1'b0;
    io.carry_in = 1'b0;
    io.A = 16'h0000;
    io.B = 16'h0000;
    io.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    test_single_add();
    test_two_word_add();
    test_two_word_sub();
    test_backpressure();
    test_mode_change();
    test_reset_mid_chain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule : tb_addsub_chain_seq

// File: doc/addsub_chain_seq.md
Name: addsub_chain_seq

Overview:
- Sequential multi-precision adder/subtractor that wraps one addsub_bin instance.
- Accepts operand word pairs least-significant word first, one pair per handshake. The carry is held between words in a register, and each result word appears in a registered output stage.
- Sits between the operand-fetch stage and the result writeback stage, so any operand width becomes a chain of WORD_WIDTH slices.

Parameters:
- WORD_WIDTH, 16, width of one operand/result slice; must be 2 or more.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word pair presented.
- in_ready  output  1  block accepts the pair this cycle.
- in_last  input  1  this pair is the most-significant word of the operation.
- add_sub  input  1  0 = A+B, 1 = A-B; sampled only on the first word.
- carry_in  input  1  add: carry into LSW; sub: borrow into LSW; sampled only on the first word.
- A  input  WORD_WIDTH  minuend/augend slice.
- B  input  WORD_WIDTH  subtrahend/addend slice.
- out_valid  output  1  result slice valid.
- out_ready  input  1  downstream accepts the slice.
- out_sum  output  WORD_WIDTH  result slice.
- out_last  output  1  slice is the MSW.
- out_carry_out  output  1  word carry out; on the MSW this is the final carry (sub: 1 = no borrow).
- out_overflow  output  1  signed overflow of the slice; meaningful only with out_last.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid=0, out_sum=0, out_last=0, out_carry_out=0, out_overflow=0.
  - State=START, chain carry=0, latched mode=0.
- Handshakes:
  - Accept when in_valid && in_ready. Emit when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, so one slice can be accepted per cycle at full throughput.
  - While out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- State machine with two states: START (the next accepted pair is the LSW) and CHAIN (the operation is in progress).
  - START, accept with in_last=0 -> CHAIN.
  - START, accept with in_last=1 -> START (single-word operation).
  - CHAIN, accept with in_last=1 -> START.
  - CHAIN, accept with in_last=0 -> CHAIN.
  - No accept -> state unchanged.
- Arithmetic:
  - The addsub_bin instance is always driven with add_sub=0. Subtraction is performed at this level.
  - B_eff = B when mode=add, ~B when mode=sub.
  - cin on the first word: add -> carry_in; sub -> ~carry_in.
  - cin on later words: the stored chain carry, which is the previous slice's carry_out.
  - The mode used on the first word is add_sub as presented. On that accept, add_sub is latched and used for every later word of the operation. add_sub and carry_in presented mid-chain are ignored.
- Latency: the slice accepted in cycle N has out_valid=1 in cycle N+1. out_last mirrors the in_last of that slice.
- The chain carry register updates only on accept. It is cleared to 0 when the MSW is accepted.
- out_carry_out and out_overflow come from that slice's addsub_bin carry_out/overflow and are registered alongside out_sum.
- Reset mid-chain: any partial operation is discarded. The next accepted pair is treated as an LSW.
- Back-to-back operations are allowed: a new LSW may be accepted in the cycle after the previous MSW was accepted, with no idle cycle.
- in_valid=0 for any number of cycles mid-chain is legal; the chain carry is retained.

Decomposition:
- Shared package: state encoding constants (START, CHAIN) and the mode constants (ADD=0, SUB=1).
- One sub-module: addsub_bin, instanced with WORD_WIDTH. Its carries output is left unconnected.
- This block adds only the FSM, the latched mode, the chain carry register and the output register.

Test Plan:
- Single-word add, 0x7FFF+0x0001, cin=0, in_last=1 -> next cycle out_sum=0x8000, out_carry_out=0, out_overflow=1, out_last=1.
- Two-word add, 0x0001_FFFF+0x0000_0001 -> slice 0x0000 with out_carry_out=1, then slice 0x0002 with out_carry_out=0, out_overflow=0, out_last=1.
- Two-word sub, 0x0001_0000-0x0000_0001, borrow in=0 -> slice 0xFFFF with out_carry_out=0, then slice 0x0000 with out_carry_out=1 (no borrow), out_overflow=0.
- Backpressure: out_ready=0 for 3 cycles with a slice pending -> in_ready=0 and outputs unchanged. Releasing out_ready gives one transfer, and the next slice follows the cycle after.
- Mode change mid-chain: add_sub toggled to 1 on word 2 of an add -> result equals a pure add. Then carry_in=1 sampled on the next LSW.
- reset_n pulsed low after word 1 of 3 -> out_valid=0 immediately. The next pair 0x0003+0x0004, in_last=1, gives 0x0007 with no carry from the discarded chain.
